// File: rtl/panel_scan_ctrl.sv
// Row-pair scan sequencer for the 16x32 RGB panel.
// Shifts, blanks, latches and owns the frame-aligned screen index.
module panel_scan_ctrl #(
  parameter int COLS        = 32,
  parameter int ROWS        = 8,
  parameter int ONTIME      = 48,
  parameter int BLANK       = 2,
  parameter int NUM_SCREENS = 16,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int TW = $clog2(ONTIME + BLANK + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    screen_req,
  input  logic          screen_req_valid,
  output logic [4:0]    screen,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          sclk,
  output logic          lat,
  output logic          oe_n,
  output logic [RW-1:0] abc,
  output logic          frame_start
);

  typedef enum logic [1:0] {
    S_SHIFT,
    S_WAIT,
    S_BLANK,
    S_LATCH
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] t, t_n;
  logic          primed;
  logic [4:0]    pend;
  logic          pend_v;
  logic          last_row;
  logic          req_ok;

  assign last_row = (row == RW'(ROWS - 1));
  assign req_ok   = screen_req_valid &&
                    (32'(screen_req) < NUM_SCREENS);

  always_comb begin
    state_n = state;
    t_n     = t + 1'b1;
    unique case (state)
      S_SHIFT: begin
        if (t == TW'(COLS - 1)) begin
          t_n     = '0;
          state_n = (ONTIME > COLS) ? S_WAIT : S_BLANK;
        end
      end
      S_WAIT: begin
        if (t == TW'(ONTIME - COLS - 1)) begin
          t_n     = '0;
          state_n = S_BLANK;
        end
      end
      S_BLANK: begin
        if (t == TW'(BLANK - 1)) begin
          t_n     = '0;
          state_n = S_LATCH;
        end
      end
      S_LATCH: begin
        t_n     = '0;
        state_n = S_SHIFT;
      end
      default: begin
        t_n     = '0;
        state_n = S_SHIFT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_SHIFT;
      t      <= '0;
      row    <= '0;
      abc    <= '0;
      screen <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      primed <= 1'b0;
    end else begin
      state <= state_n;
      t     <= t_n;
      if (state == S_LATCH) begin
        abc    <= row;
        primed <= 1'b1;
        row    <= last_row ? '0 : row + 1'b1;
        if (last_row && pend_v) begin
          screen <= pend;
          pend_v <= 1'b0;
        end
      end
      // a request in the boundary cycle survives as pending
      if (req_ok) begin
        pend   <= screen_req;
        pend_v <= 1'b1;
      end
    end
  end

  assign sclk        = (state == S_SHIFT);
  assign lat         = (state == S_LATCH);
  assign oe_n        = !(primed &&
                         (state == S_SHIFT ||
                          state == S_WAIT));
  assign frame_start = (state == S_SHIFT) &&
                       (t == '0) && (row == '0);
  assign col         = (state == S_SHIFT) ?
                       t[CW-1:0] : CW'(COLS - 1);

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Scoreboard bench for panel_scan_ctrl.
// Expected outputs come from cycle-position arithmetic.
module tb_panel_scan_ctrl;

  localparam int COLS   = 32;
  localparam int ROWS   = 8;
  localparam int ONTIME = 48;
  localparam int BLANK  = 2;
  localparam int NSCR   = 16;
  localparam int RP     = ONTIME + BLANK + 1;
  localparam int FP     = ROWS * RP;

  logic       clk = 0;
  logic       reset = 0;
  logic [4:0] screen_req = '0;
  logic       screen_req_valid = 0;
  logic [4:0] screen;
  logic [4:0] col;
  logic [2:0] row;
  logic       sclk, lat, oe_n, frame_start;
  logic [2:0] abc;

  panel_scan_ctrl dut (
    .clk(clk),
    .reset(reset),
    .screen_req(screen_req),
    .screen_req_valid(screen_req_valid),
    .screen(screen),
    .col(col),
    .row(row),
    .sclk(sclk),
    .lat(lat),
    .oe_n(oe_n),
    .abc(abc),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    bit sclk, lat, oe_n, fs, ccol;
    int col, row, abc, scr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // model state
  bit mv = 0;
  int n = 0;
  int scr = 0, pend = 0;
  bit pv = 0;

  function automatic exp_t predict(int cn, int s);
    exp_t e;
    int p, r;
    p      = cn % RP;
    r      = (cn / RP) % ROWS;
    e.n    = cn;
    e.sclk = (p < COLS);
    e.lat  = (p == RP - 1);
    e.oe_n = !(p < ONTIME && cn >= RP);
    e.fs   = (p == 0 && r == 0);
    e.ccol = (p < ONTIME);
    e.col  = (p < COLS) ? p : COLS - 1;
    e.row  = r;
    e.abc  = (cn < RP) ? 0 : ((cn / RP) - 1) % ROWS;
    e.scr  = s;
    return e;
  endfunction

  task automatic chk(string nm, int cn, int got, int ex);
    checks++;
    if (got != ex) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                 nm, cn, got, ex);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sclk", e.n, int'(sclk), int'(e.sclk));
      chk("lat", e.n, int'(lat), int'(e.lat));
      chk("oe_n", e.n, int'(oe_n), int'(e.oe_n));
      chk("frame_start", e.n,
          int'(frame_start), int'(e.fs));
      chk("row", e.n, int'(row), e.row);
      chk("abc", e.n, int'(abc), e.abc);
      chk("screen", e.n, int'(screen), e.scr);
      if (e.ccol)
        chk("col", e.n, int'(col), e.col);
    end
  end

  task automatic step(bit rst, bit v, int rq);
    int p, r;
    @(posedge clk);
    #1;
    if (mv) q.push_back(predict(n, scr));
    reset            = rst;
    screen_req_valid = v;
    screen_req       = 5'(rq);
    if (rst) begin
      mv = 1; n = 0; scr = 0; pend = 0; pv = 0;
    end else if (mv) begin
      p = n % RP;
      r = (n / RP) % ROWS;
      if (p == RP - 1 && r == ROWS - 1 && pv) begin
        scr = pend;
        pv  = 0;
      end
      if (v && rq < NSCR) begin
        pend = rq;
        pv   = 1;
      end
      n++;
    end
  endtask

  task automatic run(int cnt);
    for (int i = 0; i < cnt; i++) step(0, 0, 0);
  endtask

  task automatic req_at(int when, int rq);
    while (n < when) step(0, 0, 0);
    step(0, 1, rq);
  endtask

  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    // screen 9 wins over 5 at first boundary
    req_at(100, 5);
    req_at(200, 9);
    run(2 * FP + 20);

    // boundary-cycle request deferred; out-of-range dropped
    step(1, 0, 0);
    req_at(FP - 1, 3);
    req_at(FP + 100, 20);
    run(2 * FP + 10);
    req_at(n + 50, 25);
    run(FP + 10);

    // reset mid-WAIT of row 4 clears pending 7
    step(1, 0, 0);
    req_at(60, 7);
    while (n < 4 * RP + 40) step(0, 0, 0);
    step(1, 0, 0);
    run(FP + 20);

    // random requests and occasional resets
    for (int i = 0; i < 6000; i++) begin
      int k;
      k = $urandom_range(0, 999);
      if (k < 2)
        step(1, 0, 0);
      else if (k < 30)
        step(0, 1, $urandom_range(0, 31));
      else
        step(0, 0, 0);
    end
    step(0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
